// File: rtl/toast_pkg.sv
// toast_pkg: shared definitions for the data-memory bus bridge.
//   - RV32I load/store funct3 encodings
//   - bridge FSM state enum
//   - write-strobe base patterns
//   - helper that decides whether a core access may go to the bus
package toast_pkg;

  // Load funct3 encodings
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } bridge_state_e;

  // Strobe patterns before shifting into the addressed lane
  localparam logic [3:0] WSTRB_NONE = 4'b0000;
  localparam logic [3:0] WSTRB_BYTE = 4'b0001;
  localparam logic [3:0] WSTRB_HALF = 4'b0011;
  localparam logic [3:0] WSTRB_WORD = 4'b1111;

  // An access is legal when the funct3 exists for its direction and the
  // address is naturally aligned for the access size (op[1:0] encodes size).
  function automatic logic mem_access_legal(input logic       is_store,
                                            input logic [2:0] op,
                                            input logic [1:0] addr_lo);
    logic op_ok;
    logic aligned;
    if (is_store) begin
      op_ok = (op == F3_SB) || (op == F3_SH) || (op == F3_SW);
    end else begin
      op_ok = (op == F3_LB) || (op == F3_LH) || (op == F3_LW) ||
              (op == F3_LBU) || (op == F3_LHU);
    end
    case (op[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~addr_lo[0];
      2'b10:   aligned = (addr_lo == 2'b00);
      default: aligned = 1'b0;
    endcase
    return op_ok && aligned;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational lane steering for the bus bridge.
// Ports:
//   op_i       funct3 of the latched access
//   we_i       1 = store, 0 = load
//   addr_lo_i  byte offset within the word
//   wdata_i    store data, value in the low bits
//   rdata_i    raw word returned by the bus
//   wstrb_o    byte-enable for the bus (0000 for loads)
//   wdata_o    store data replicated across all lanes it may land in
//   rdata_o    selected and sign/zero-extended load result
module dmem_lane_align
  import toast_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic        we_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    wstrb_o = WSTRB_NONE;
    if (we_i) begin
      case (op_i)
        F3_SB:   wstrb_o = WSTRB_BYTE << addr_lo_i;
        F3_SH:   wstrb_o = WSTRB_HALF << {addr_lo_i[1], 1'b0};
        F3_SW:   wstrb_o = WSTRB_WORD;
        default: wstrb_o = WSTRB_NONE;
      endcase
    end
  end

  // Replicating the datum into every lane lets the strobe alone pick the
  // destination, so no data shifter is needed.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign wdata_o[8*gi +: 8] = (op_i == F3_SB) ? wdata_i[7:0] :
                                (op_i == F3_SH) ? wdata_i[8*(gi%2) +: 8] :
                                                  wdata_i[8*gi +: 8];
  end

  assign rbyte = rdata_i[{addr_lo_i, 3'b000} +: 8];
  assign rhalf = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    rdata_o = rdata_i;
    case (op_i)
      F3_LB:   rdata_o = {{24{rbyte[7]}}, rbyte};
      F3_LBU:  rdata_o = {24'h0, rbyte};
      F3_LH:   rdata_o = {{16{rhalf[15]}}, rhalf};
      F3_LHU:  rdata_o = {16'h0, rhalf};
      default: rdata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/dmem_bus_bridge.sv
// dmem_bus_bridge: turns single core MEM-stage loads/stores into one
// valid/ready bus request plus one response, stalling the core meanwhile.
// Ports:
//   Clk, Reset                      clock, async active-high reset
//   Core_addr/wr_data/wr_en/rd_en/op  core access request
//   Core_rd_data                    formatted load result (held)
//   Core_stall                      freezes the core while busy
//   Core_exception                  one-cycle fault pulse
//   Bus_req_*                       request channel (valid/ready)
//   Bus_rsp_*                       response channel (valid, data, error)
// Parameter TIMEOUT_CYCLES bounds the cycles spent in REQ+RESP.
module dmem_bus_bridge
  import toast_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] Core_addr,
  input  logic [31:0] Core_wr_data,
  input  logic        Core_wr_en,
  input  logic        Core_rd_en,
  input  logic [2:0]  Core_op,
  output logic [31:0] Core_rd_data,
  output logic        Core_stall,
  output logic        Core_exception,
  output logic        Bus_req_valid,
  input  logic        Bus_req_ready,
  output logic [31:0] Bus_req_addr,
  output logic        Bus_req_we,
  output logic [3:0]  Bus_req_wstrb,
  output logic [31:0] Bus_req_wdata,
  input  logic        Bus_rsp_valid,
  input  logic [31:0] Bus_rsp_rdata,
  input  logic        Bus_rsp_err
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  bridge_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  op_q, op_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        err_q, err_d;

  logic        access;
  logic        legal;
  logic        timeout;
  logic [31:0] load_fmt;

  dmem_lane_align u_lane_align (
    .op_i      (op_q),
    .we_i      (we_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   (wdata_q),
    .rdata_i   (Bus_rsp_rdata),
    .wstrb_o   (Bus_req_wstrb),
    .wdata_o   (Bus_req_wdata),
    .rdata_o   (load_fmt)
  );

  assign access  = Core_rd_en ^ Core_wr_en;
  assign legal   = access && mem_access_legal(Core_wr_en, Core_op, Core_addr[1:0]);
  // The final allowed cycle is the one where the count sits at TIMEOUT-1;
  // forward progress on that cycle still wins over the abort.
  assign timeout = (cnt_q >= CNT_LAST);

  assign Bus_req_addr = {addr_q[31:2], 2'b00};
  assign Bus_req_we   = we_q;
  assign Core_rd_data = rd_data_q;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    op_d           = op_q;
    we_d           = we_q;
    wdata_d        = wdata_q;
    rd_data_d      = rd_data_q;
    err_d          = err_q;
    Core_stall     = 1'b0;
    Core_exception = 1'b0;
    Bus_req_valid  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        err_d = 1'b0;
        if (legal) begin
          // Stall in the same cycle so the core holds the instruction.
          Core_stall = 1'b1;
          addr_d     = Core_addr;
          op_d       = Core_op;
          we_d       = Core_wr_en;
          wdata_d    = Core_wr_data;
          cnt_d      = '0;
          state_d    = ST_REQ;
        end else if (Core_rd_en || Core_wr_en) begin
          // Misaligned, bad funct3, or both enables: fault without the bus.
          Core_exception = 1'b1;
        end
      end

      ST_REQ: begin
        Core_stall    = 1'b1;
        Bus_req_valid = 1'b1;
        cnt_d         = cnt_q + CNT_W'(1);
        if (Bus_req_ready) begin
          state_d = ST_RESP;
        end else if (timeout) begin
          err_d     = 1'b1;
          rd_data_d = '0;
          state_d   = ST_DONE;
        end
      end

      ST_RESP: begin
        Core_stall = 1'b1;
        cnt_d      = cnt_q + CNT_W'(1);
        if (Bus_rsp_valid) begin
          if (Bus_rsp_err) begin
            err_d     = 1'b1;
            rd_data_d = '0;
          end else if (!we_q) begin
            rd_data_d = load_fmt;
          end
          state_d = ST_DONE;
        end else if (timeout) begin
          err_d     = 1'b1;
          rd_data_d = '0;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        // Core request is still on the inputs here but must not re-trigger.
        Core_exception = err_q;
        state_d        = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      op_q      <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      rd_data_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      op_q      <= op_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: doc/dmem_bus_bridge.md
DMEM_BUS_BRIDGE -- requirements
Module: dmem_bus_bridge

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-high; ports named Clk and Reset.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent in REQ+RESP before abort.
REQ-003 SHALL have port Clk, input, 1, clock.
REQ-004 SHALL have port Reset, input, 1, async active-high reset.
REQ-005 SHALL have port Core_addr, input, 32, byte address from the core MEM stage.
REQ-006 SHALL have port Core_wr_data, input, 32, store data in the low bits.
REQ-007 SHALL have ports Core_wr_en and Core_rd_en, input, 1 each, store and load request.
REQ-008 SHALL have port Core_op, input, 3, RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 SHALL have port Core_rd_data, output, 32, formatted load result.
REQ-010 SHALL have port Core_stall, output, 1, which freezes the core pipeline.
REQ-011 SHALL have port Core_exception, output, 1, a one-cycle fault pulse.
REQ-012 SHALL have port Bus_req_valid, output, 1, and port Bus_req_ready, input, 1.
REQ-013 SHALL have port Bus_req_addr, output, 32, word-aligned with bits [1:0]=0.
REQ-014 SHALL have ports Bus_req_we (1), Bus_req_wstrb (4) and Bus_req_wdata (32), all outputs.
REQ-015 SHALL have ports Bus_rsp_valid (1), Bus_rsp_rdata (32) and Bus_rsp_err (1), all inputs.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, RESP and DONE.
REQ-017 In IDLE, an access is Core_rd_en xor Core_wr_en; SHALL be legal only if aligned (LH/LHU/SH addr[0]=0; LW/SW addr[1:0]=0) and Core_op is valid for the direction.
REQ-018 A legal access in IDLE SHALL combinationally assert Core_stall, latch addr/op/we/wdata, and go to REQ next cycle.
REQ-019 An illegal access (misaligned, bad op, or rd_en and wr_en both high) SHALL pulse Core_exception for one cycle, issue no bus request, leave Core_stall=0, and stay in IDLE.
REQ-020 In REQ, SHALL hold Bus_req_valid=1 with stable payload until Bus_req_ready=1, then go to RESP.
REQ-021 In RESP, SHALL wait for Bus_rsp_valid; on it, SHALL register the formatted rdata (loads only) and go to DONE.
REQ-022 Core_stall SHALL be 1 in REQ and RESP, and 0 in DONE.
REQ-023 DONE SHALL last exactly one cycle; the still-present core request SHALL be ignored; SHALL go to IDLE next.
REQ-024 If Bus_rsp_err=1 with Bus_rsp_valid, Core_exception SHALL pulse in DONE and Core_rd_data SHALL be 0.
REQ-025 A cycle counter SHALL clear on entering REQ; if it reaches TIMEOUT_CYCLES, SHALL drop Bus_req_valid, go to DONE, pulse Core_exception, and set rd_data=0; a late response SHALL be ignored.
REQ-026 Store lanes: SB SHALL set wstrb=0001<<addr[1:0] and replicate the byte ×4; SH SHALL set wstrb=0011<<(2·addr[1]) and replicate the half ×2; SW SHALL set wstrb=1111.
REQ-027 Loads SHALL select the byte or half by latched addr; LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend.
REQ-028 Core_rd_data SHALL hold its value until the next load completes.
REQ-029 Minimum latency SHALL be 3 cycles of stall for zero-wait bus (ready in REQ, rsp one cycle later), with release in the 4th cycle.
REQ-030 For loads, Bus_req_we SHALL be 0 and Bus_req_wstrb SHALL be 0000.

Reset
REQ-031 Reset SHALL force IDLE immediately; Bus_req_valid=0, Core_stall=0, Core_exception=0, Core_rd_data=0, and the counter 0.
REQ-032 Reset mid-transaction SHALL abandon the access; responses arriving after reset SHALL be ignored until a new REQ is issued.

Structure
REQ-033 Package toast_pkg SHALL hold the mem_op funct3 constants, the bridge state enum, and the wstrb constants.
REQ-034 Lane steering and extension SHALL be in the combinational sub-module dmem_lane_align; the FSM and counter SHALL be in dmem_bus_bridge.

Verification
REQ-035 LW addr 0x100, ready immediate, rsp next cycle with 0xDEADBEEF -> stall for 3 cycles, then rd_data=0xDEADBEEF, no exception.
REQ-036 SB addr 0x203, data 0x000000A5 -> Bus_req_addr=0x200, wstrb=1000, wdata=0xA5A5A5A5, we=1.
REQ-037 LB addr 0x101, rdata 0x0000_80_00 -> rd_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-038 LW addr 0x102 -> exception pulses 1 cycle, Bus_req_valid never asserts, stall=0.
REQ-039 Ready held low 300 cycles with TIMEOUT_CYCLES=255 -> exception in DONE at cycle 256, rd_data=0, then IDLE.
REQ-040 Reset asserted in RESP, then rsp_valid arrives -> state IDLE, stall=0, rsp ignored, rd_data=0.
